// File: rtl/mic_cmd_rx.sv
// mic_cmd_rx: UART (8N1, LSB first) command receiver that turns byte pairs
// into register writes. A byte with bit7=1 is an address (addr = byte[6:0]);
// the next valid byte is the data, and it produces a one-cycle wr_en strobe.
// Bytes with bit7=0 that arrive while no address is pending are fillers and
// are dropped.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rxd        UART serial input, idle high, asynchronous to clk
//   wr_en      one-cycle register-write strobe
//   wr_addr    7-bit write address, held until the next write
//   wr_data    8-bit write data, held until the next write
//   frame_err  one-cycle pulse when a stop bit samples low
//   tmo_err    one-cycle pulse when a pending address times out
//   busy       high while an address is waiting for its data byte
module mic_cmd_rx #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned TIMEOUT  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       tmo_err,
  output logic       busy
);

  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_st_e;
  typedef enum logic {P_ADDR, P_DATA} par_st_e;

  // ---------------------------------------------------------------------
  // Synchronizer plus one extra flop for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // ---------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------
  bit_st_e     bst_q, bst_d;
  logic [15:0] tmr_q, tmr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        brk_q, brk_d;    // stop bit was low; waiting for line to recover
  logic        byte_valid;
  logic        ferr_now;
  logic        tmr_zero;

  assign tmr_zero = (tmr_q == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bst_q  <= S_IDLE;
      tmr_q  <= '0;
      bcnt_q <= '0;
      sh_q   <= '0;
      brk_q  <= 1'b0;
    end else begin
      bst_q  <= bst_d;
      tmr_q  <= tmr_d;
      bcnt_q <= bcnt_d;
      sh_q   <= sh_d;
      brk_q  <= brk_d;
    end
  end

  always_comb begin
    bst_d      = bst_q;
    tmr_d      = tmr_q;
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    brk_d      = brk_q;
    byte_valid = 1'b0;
    ferr_now   = 1'b0;
    unique case (bst_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          bst_d = S_START;
          tmr_d = HALF_BIT;
        end
      end
      S_START: begin
        if (tmr_zero) begin
          if (!rx_s2_q) begin
            bst_d  = S_DATA;
            tmr_d  = FULL_BIT;
            bcnt_d = '0;
          end else begin
            bst_d = S_IDLE;     // start bit did not hold to mid-bit: glitch
          end
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tmr_zero) begin
          sh_d   = {rx_s2_q, sh_q[7:1]};
          tmr_d  = FULL_BIT;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) bst_d = S_STOP;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_STOP: begin
        if (brk_q) begin
          if (rx_s2_q) begin
            bst_d = S_IDLE;
            brk_d = 1'b0;
          end
        end else if (tmr_zero) begin
          if (rx_s2_q) begin
            // Leave at mid-stop so a start bit right after the stop bit is
            // seen as a fresh falling edge.
            byte_valid = 1'b1;
            bst_d      = S_IDLE;
          end else begin
            ferr_now = 1'b1;
            brk_d    = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      default: bst_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Address/data parser
  // ---------------------------------------------------------------------
  par_st_e       pst_q, pst_d;
  logic [6:0]    addr_q, addr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wr_en_q, wr_en_d;
  logic [6:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          ferr_q, ferr_d;
  logic          tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst_q     <= P_ADDR;
      addr_q    <= '0;
      tcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ferr_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      pst_q     <= pst_d;
      addr_q    <= addr_d;
      tcnt_q    <= tcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ferr_q    <= ferr_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    pst_d     = pst_q;
    addr_d    = addr_q;
    tcnt_d    = tcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ferr_d    = ferr_now;
    tmo_d     = 1'b0;
    unique case (pst_q)
      P_ADDR: begin
        tcnt_d = '0;
        if (byte_valid && sh_q[7]) begin
          addr_d = sh_q[6:0];
          pst_d  = P_DATA;
        end
      end
      P_DATA: begin
        tcnt_d = tcnt_q + 1'b1;
        // Byte is checked first so it beats a timeout in the same cycle.
        if (byte_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = sh_q;
          pst_d     = P_ADDR;
        end else if (ferr_now) begin
          addr_d = '0;
          pst_d  = P_ADDR;
        end else if (tcnt_q == TMO_LAST) begin
          tmo_d  = 1'b1;
          addr_d = '0;
          pst_d  = P_ADDR;
        end
      end
      default: pst_d = P_ADDR;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = ferr_q;
  assign tmo_err   = tmo_q;
  assign busy      = (pst_q == P_DATA);

endmodule

// File: doc/mic_cmd_rx.md
MIC_CMD_RX -- requirements
Module: mic_cmd_rx

Interface
REQ-001 Parameter BAUD_DIV, default 434, meaning clk cycles per UART bit (legal 8..65535).
REQ-002 Parameter TIMEOUT, default 2000000, meaning max clk cycles allowed between address byte and data byte.
REQ-003 clk  input  1  system clock; all logic is synchronous to rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; one clock domain only.
REQ-005 rxd  input  1  UART serial input, idle high, 8N1, LSB first; asynchronous to clk.
REQ-006 wr_en  output  1  one-cycle register-write strobe.
REQ-007 wr_addr  output  7  register address; valid while wr_en=1, held until the next write.
REQ-008 wr_data  output  8  register data; valid while wr_en=1, held until the next write.
REQ-009 frame_err  output  1  one-cycle pulse when a byte's stop bit samples low.
REQ-010 tmo_err  output  1  one-cycle pulse when a pending address byte times out.
REQ-011 busy  output  1  high while the parser holds an address awaiting data.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 The bit engine SHALL use states IDLE, START, DATA, STOP and a 16-bit bit-timer.
REQ-014 IDLE -> START on a synchronized high-to-low transition; the timer loads BAUD_DIV/2 (floor).
REQ-015 START: at timer expiry, if rxd=0, go to DATA with timer=BAUD_DIV-1; if rxd=1 (glitch), return to IDLE with no output.
REQ-016 DATA: sample 8 bits, one every BAUD_DIV cycles, shifting LSB first; after bit 7, go to STOP.
REQ-017 STOP: sample at mid-bit; rxd=1 yields byte_valid for 1 cycle; rxd=0 pulses frame_err, drops the byte, and waits for rxd=1 before IDLE.
REQ-018 The parser SHALL have states WAIT_ADDR and WAIT_DATA.
REQ-019 WAIT_ADDR: a byte with bit7=1 latches addr=byte[6:0] and goes to WAIT_DATA; a byte with bit7=0 is discarded (sync/filler byte).
REQ-020 WAIT_DATA: any valid byte, including one with bit7=1, is data: wr_en=1 for exactly one cycle with the latched addr and byte, then go to WAIT_ADDR.
REQ-021 wr_en SHALL assert on the clk edge immediately after the byte_valid cycle, giving a fixed 1-cycle latency from the stop-bit sample.
REQ-022 WAIT_DATA SHALL run a timeout counter cleared on entry; on reaching TIMEOUT it pulses tmo_err, discards addr and returns to WAIT_ADDR.
REQ-023 A frame_err while in WAIT_DATA SHALL also return the parser to WAIT_ADDR with no write.
REQ-024 If byte_valid and timeout expiry occur in the same cycle, the byte wins: write issued, no tmo_err.
REQ-025 busy = (parser state == WAIT_DATA).
REQ-026 Back-to-back bytes with zero idle time after the stop bit SHALL be received without loss.

Reset
REQ-027 rst=0 SHALL immediately force: bit engine IDLE, parser WAIT_ADDR, synchronizer flops=1, counters=0, wr_en=0, wr_addr=0, wr_data=0, frame_err=0, tmo_err=0, busy=0.
REQ-028 Reset asserted mid-byte SHALL discard the partial byte and any pending address; after release, the first start edge seen is a new frame.

Verification (BAUD_DIV=16, TIMEOUT=1000)
REQ-029 Bytes 0x86,0x96 -> one wr_en, wr_addr=0x06, wr_data=0x96, 1 cycle after stop sample.
REQ-030 Bytes 0x00,0x01,0x82,0x85 -> leading bytes ignored; single write addr=0x02 data=0x85.
REQ-031 Byte 0x9a then idle for 1000 cycles -> tmo_err pulse, busy drops, no write; next 0x9b,0x9e -> write addr=0x1b data=0x9e.
REQ-032 Byte with stop bit forced 0 while busy -> frame_err pulse, busy=0, no write.
REQ-033 4-cycle low glitch on rxd -> no byte, no error outputs.
REQ-034 rst pulsed low mid-data-byte of pair 0x87,0x07 -> no write; a following 0x87,0x07 -> write addr=0x07 data=0x07.
